uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- Serial receiver that sits directly upstream of the RGB colour-toggle FSM.
- Recovers 8N1 asynchronous bytes from a host serial line (ASCII 'R'/'G'/'B' commands) and presents each byte on an 8-bit command bus for exactly one clock. At all other times the bus holds 0x00.
- The downstream FSM reacts to any change on its command bus, so the single-cycle pulse with a 0x00 idle value guarantees exactly one transition per received byte, including repeated identical bytes.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per serial bit (50 MHz / 115200 baud); minimum legal value 4.
- CNT_W, 16, Width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- Clock  input  1  System clock; all state updates on its rising edge.
- Reset  input  1  Asynchronous, active-high reset.
- Rx  input  1  Asynchronous serial input. Idles high, LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- Cmd  output  8  Received byte, valid for exactly one cycle; 0x00 otherwise.
- CmdValid  output  1  High in the same single cycle that Cmd carries a byte.
- FrameError  output  1  One-cycle pulse when a stop bit samples low.

Behaviour:
- Reset (async, active-high):
  - Synchroniser flops = 1; state = IDLE; counters = 0; shift register = 0.
  - Cmd = 0x00, CmdValid = 0, FrameError = 0.
  - Takes effect immediately, including mid-frame; a partial frame is discarded with no output.
- Synchroniser: Rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Outputs are registered; no combinational path from Rx to any output.
- States:
  - IDLE:
    - Counter cleared. rx_s==0 -> START.
  - START:
    - Count to CLKS_PER_BIT/2 - 1 (integer division), then sample rx_s at the start-bit midpoint.
    - Sample 0 -> DATA with bit index 0 and counter cleared.
    - Sample 1 -> false start (glitch) -> IDLE; no output.
  - DATA:
    - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
    - After bit index 7 is sampled -> STOP.
  - STOP:
    - After CLKS_PER_BIT cycles, sample rx_s.
    - Sample 1 -> DONE.
    - Sample 0 -> FrameError pulses for 1 cycle -> BREAK.
  - DONE:
    - For one cycle, Cmd = shift register and CmdValid = 1; then -> IDLE.
    - The next cycle Cmd returns to 0x00 and CmdValid to 0.
  - BREAK:
    - Cmd stays 0x00. Wait until rx_s==1, then -> IDLE. A held-low line (break) produces only one FrameError.
- Timing, with T0 = first cycle IDLE sees rx_s==0:
  - Start midpoint at T0 + CLKS_PER_BIT/2.
  - Data bit k midpoint at T0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - Stop midpoint at T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - Cmd/CmdValid asserted the cycle after the stop sample.
- Back-to-back frames:
  - The receiver returns to IDLE at the stop-bit midpoint plus 1 cycle, so a start bit immediately following the stop bit is captured.
  - Required tolerance: ±2% baud mismatch with no errors.
- Byte value 0x00 with a valid stop bit: CmdValid pulses, Cmd stays 0x00. Downstream treats it as a no-op.
- No buffering. The module never stalls; each byte is presented once and not held.

Test Plan:
- Use CLKS_PER_BIT=16 in all scenarios.
- Reset: assert Reset for 3 cycles with Rx=1 -> Cmd=0x00, CmdValid=0, FrameError=0. Assert Reset asynchronously between clock edges -> outputs clear before the next edge.
- Single byte: send 0x52 ('R') -> Cmd=0x52 and CmdValid=1 for exactly 1 cycle, 2+8+9*16+1 cycles after the Rx falling edge (±1). Cmd=0x00 in all other cycles.
- Back-to-back 'G','G': send 0x47 twice with no idle gap -> two separate one-cycle pulses of 0x47, separated by 160 cycles (±1), with 0x00 between them.
- Glitch: drive Rx low for 5 cycles, then high -> no CmdValid, no FrameError, state back to IDLE. A following 0x42 ('B') is received correctly.
- Framing error: send 0x42 with the stop bit held low for 3 bit times -> exactly one FrameError pulse, CmdValid never asserts. After Rx returns high, a following 0x52 is received correctly.
- Reset mid-frame: assert Reset during data bit 4 of 0x47, release, then send 0x52 -> no output for the aborted frame, Cmd=0x52 for the next frame.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 serial receiver feeding the RGB colour-toggle FSM.
// Each good byte is shown on cmd_o for exactly one clock (0x00 at all
// other times). Because the idle value is 0x00, the downstream FSM sees one
// transition per byte, even when the same byte arrives twice in a row.
// A stop bit that samples low raises a one-cycle frame_error_o pulse. The
// receiver then waits for the line to return high, so a held break gives
// only one error.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,  // 50 MHz / 115200 baud, must be >= 4
  parameter int CNT_W        = 16    // 2**CNT_W must exceed CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] cmd_o,
  output logic       cmd_valid_o,
  output logic       frame_error_o
);

  // Receiver states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;

  // Last count of a half bit (start-bit midpoint) and of a full bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_s;

  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       cmd_q,       cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frm_err_q,   frm_err_d;

  // Two-flop synchroniser. It resets to the idle-high line level, so
  // leaving reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_i};
  end

  assign rx_s = sync_q[1];

  // Frame sequencing. Output pulses are computed here at the stop-bit
  // sample, then registered, so they appear in the DONE cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    cmd_d       = 8'h00;
    cmd_valid_d = 1'b0;
    frm_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high before mid-start: treat it as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d     = S_DONE;
            cmd_d       = shift_q;
            cmd_valid_d = 1'b1;
          end else begin
            state_d   = S_BREAK;
            frm_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The output pulse is visible during this cycle. Returning to IDLE
      // right away lets a start bit that follows immediately be caught.
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      // Stay here while the line is held low, so a break gives one error.
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any partial frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Registered outputs, so there is no combinational path from rx_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frm_err_q   <= frm_err_d;
    end
  end

  assign cmd_o         = cmd_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign frame_error_o = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scoreboard bench for uart_cmd_rx with CLKS_PER_BIT=16.
// The driver pushes the expected event (byte or frame error, plus its cycle)
// when it starts a frame. A negedge monitor pops and compares each event
// when the DUT produces it. Every other cycle must show cmd == 0x00.
module tb_uart_cmd_rx;
  localparam int BIT = 16;
  localparam int LAT = 2 + 8 + 9 * BIT + 1;  // rx fall -> output cycle

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  uart_cmd_rx #(.CLKS_PER_BIT(BIT), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .cmd_o        (cmd),
    .cmd_valid_o  (cmd_valid),
    .frame_error_o(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: match each output event against the scoreboard head.
  always @(negedge clk) begin
    if (cmd_valid || frame_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {30'd0, cmd_valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind", {30'd0, cmd_valid, frame_err}, e.err ? 32'd1 : 32'd2);
        chk("cmd", {24'd0, cmd}, e.err ? 32'd0 : {24'd0, e.data});
        chk("latency", cyc - e.cyc, LAT);
      end
    end else begin
      chk("idle_cmd", {24'd0, cmd}, 32'd0);
    end
  end

  // Drive one frame, starting right after a negedge. stop_low > 0 holds the
  // stop bit low for that many bit times.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    exp_t e;
    rx    = 1'b0;
    e.err = (stop_low != 0);
    e.data = b;
    e.cyc = cyc;
    sb.push_back(e);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_low != 0) begin
      rx = 1'b0;
      repeat (stop_low * BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {23'd0, cmd, cmd_valid, frame_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] g;
    g = 8'h47;

    // Reset held for 3 cycles with the line idle.
    repeat (3) begin
      @(negedge clk);
      chk_outs_zero("reset_outs");
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single 'R'
    send_frame(8'h52, 0);
    repeat (5) @(negedge clk);

    // Back-to-back 'G','G' with no idle gap
    send_frame(8'h47, 0);
    send_frame(8'h47, 0);
    repeat (5) @(negedge clk);

    // Glitch of 5 cycles, then a real 'B'
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'h42, 0);
    repeat (5) @(negedge clk);

    // Framing error: stop bit held low for 3 bit times, then 'R'
    send_frame(8'h42, 3);
    repeat (BIT) @(negedge clk);
    send_frame(8'h52, 0);
    repeat (5) @(negedge clk);

    // Zero byte: a valid pulse that carries 0x00
    send_frame(8'h00, 0);
    repeat (5) @(negedge clk);

    // Reset in the middle of data bit 4 of 'G', then 'R'
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = g[i];
      repeat (BIT) @(negedge clk);
    end
    rx = g[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_outs_zero("midframe_reset_outs");
    rst = 1'b0;
    rx  = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h52, 0);
    repeat (5) @(negedge clk);

    // Reset raised between edges during an output pulse. The outputs must
    // clear at once, before the next clock edge.
    fork
      send_frame(8'h41, 0);
    join_none
    for (int i = 0; i < 400 && !cmd_valid; i++) @(negedge clk);
    chk("async_pulse_seen", {31'd0, cmd_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_outs_zero("async_reset_outs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
